// File: rtl/mpsoc_dbg_jsp_wb_master_if.sv
// Wishbone bus bundle between the JSP master and the JSP slave.
// 8-bit data, 3-bit register address, classic single-beat cycles.
interface mpsoc_dbg_jsp_wb_master_if;
    logic       wbm_cyc_o;
    logic       wbm_stb_o;
    logic       wbm_we_o;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_ack_i;
    logic       wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/mpsoc_dbg_jsp_wb_master.sv
// CPU-side Wishbone master for the JSP 16550-style slave: polls LSR, moves rx/tx bytes.
// Define MPSOC_DBG_JSP_WBM_IRQ_EN to poll on slave interrupt instead of a timer.
module mpsoc_dbg_jsp_wb_master #(
    parameter int POLL_INTERVAL = 64,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
`ifdef MPSOC_DBG_JSP_WBM_IRQ_EN
    input  logic       int_i,
`endif
    output logic       err_o,
    input  logic       err_clr_i,
    mpsoc_dbg_jsp_wb_master_if.master wbm
);

    typedef enum logic [2:0] {INIT, IDLE, POLL, READ, WRITE} state_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

`ifdef MPSOC_DBG_JSP_WBM_IRQ_EN
    localparam logic [7:0] IER_VAL = 8'h01;
`else
    localparam logic [7:0] IER_VAL = 8'h00;
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    logic [PW-1:0] poll_cnt;
`endif

    state_t        state, state_n;
    logic [7:0]    tx_hold;
    logic          last_was_rx;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, bus_end, bus_fail, bus_ok;
    logic          start, idle_go, tx_full;

    assign tx_full  = ~tx_ready_o;
    assign tmo_hit  = tmo_cnt == TW'(ACK_TIMEOUT - 1);
    // err beats ack; ack beats a simultaneous timeout
    assign bus_end  = wbm.wbm_cyc_o & (wbm.wbm_ack_i | wbm.wbm_err_i | tmo_hit);
    assign bus_fail = wbm.wbm_cyc_o & (wbm.wbm_err_i | (tmo_hit & ~wbm.wbm_ack_i));
    assign bus_ok   = bus_end & ~bus_fail;
    assign start    = (state != IDLE) & ~wbm.wbm_cyc_o;

`ifdef MPSOC_DBG_JSP_WBM_IRQ_EN
    assign idle_go = int_i | tx_full;
`else
    assign idle_go = tx_full | (poll_cnt == PW'(POLL_INTERVAL - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != IDLE || idle_go) poll_cnt <= '0;
        else                                      poll_cnt <= poll_cnt + 1'b1;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= INIT;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            INIT:  if (bus_end) state_n = IDLE;
            IDLE:  if (idle_go) state_n = POLL;
            POLL: begin
                if (bus_end) state_n = IDLE;
                // alternate directions so neither rx nor tx starves
                if (bus_ok) begin
                    if (wbm.wbm_dat_i[0] & ~rx_valid_o & ~last_was_rx)
                        state_n = READ;
                    else if (wbm.wbm_dat_i[5] & tx_full)
                        state_n = WRITE;
                    else if (wbm.wbm_dat_i[0] & ~rx_valid_o)
                        state_n = READ;
                end
            end
            READ:  if (bus_end) state_n = IDLE;
            WRITE: if (bus_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_adr_o <= 3'd0;
            wbm.wbm_dat_o <= 8'h00;
        end else if (start) begin
            wbm.wbm_cyc_o <= 1'b1;
            wbm.wbm_stb_o <= 1'b1;
            unique case (state)
                INIT: begin
                    wbm.wbm_we_o  <= 1'b1;
                    wbm.wbm_adr_o <= 3'd1;
                    wbm.wbm_dat_o <= IER_VAL;
                end
                POLL: begin
                    wbm.wbm_we_o  <= 1'b0;
                    wbm.wbm_adr_o <= 3'd5;
                    wbm.wbm_dat_o <= 8'h00;
                end
                WRITE: begin
                    wbm.wbm_we_o  <= 1'b1;
                    wbm.wbm_adr_o <= 3'd0;
                    wbm.wbm_dat_o <= tx_hold;
                end
                default: begin
                    wbm.wbm_we_o  <= 1'b0;
                    wbm.wbm_adr_o <= 3'd0;
                    wbm.wbm_dat_o <= 8'h00;
                end
            endcase
        end else if (bus_end) begin
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !wbm.wbm_cyc_o || bus_end) tmo_cnt <= '0;
        else                                       tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_ready_o <= 1'b1;
            tx_hold    <= 8'h00;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_ready_o <= 1'b0;
            tx_hold    <= tx_data_i;
        end else if (state == WRITE && bus_ok) begin
            tx_ready_o <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h00;
        end else if (state == READ && bus_ok) begin
            rx_valid_o <= 1'b1;
            rx_data_o  <= wbm.wbm_dat_i;
        end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)       err_o <= 1'b0;
        else if (bus_fail)  err_o <= 1'b1;
        else if (err_clr_i) err_o <= 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            last_was_rx <= 1'b0;
        else if (state == POLL && state_n == READ)
            last_was_rx <= 1'b1;
        else if (state == POLL && state_n == WRITE)
            last_was_rx <= 1'b0;
    end

endmodule
